// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 bit multiplexer.
package mux_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int N_DEF     = 2 ** SEL_W_DEF;

  localparam logic                 Y_RST   = 1'b0;
  localparam logic [SEL_W_DEF-1:0] SEL_RST = '0;

endpackage : mux_pkg

// File: rtl/mux_sel_comb.sv
// Purely combinational N:1 bit select; every select code addresses a real input.
module mux_sel_comb #(
  parameter int SEL_W = mux_pkg::SEL_W_DEF,
  localparam int N    = 2 ** SEL_W
) (
  input  logic [N-1:0]     i,
  input  logic [SEL_W-1:0] s,
  output logic             y_next
);

  assign y_next = i[s];

endmodule : mux_sel_comb

// File: rtl/mux_4to1.sv
// Registered N:1 bit multiplexer with select echo, valid flag and change pulse.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  localparam int N    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  input  logic [N-1:0]     i,
  output logic             y,
  output logic [SEL_W-1:0] sel_q,
  output logic             valid,
  output logic             y_chg
);

  logic             y_next;
  logic             y_q, y_d;
  logic [SEL_W-1:0] sel_cap_q, sel_cap_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;

  mux_sel_comb #(.SEL_W(SEL_W)) u_sel (
    .i      (i),
    .s      (s),
    .y_next (y_next)
  );

  always_comb begin
    y_d       = y_q;
    sel_cap_d = sel_cap_q;
    valid_d   = valid_q;
    chg_d     = 1'b0;
    if (en) begin
      y_d       = y_next;
      sel_cap_d = s;
      valid_d   = 1'b1;
      // No change is reported against the reset value of y.
      chg_d     = valid_q && (y_next != y_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= Y_RST;
      sel_cap_q <= SEL_W'(SEL_RST);
      valid_q   <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_cap_q <= sel_cap_d;
      valid_q   <= valid_d;
      chg_q     <= chg_d;
    end
  end

  assign y     = y_q;
  assign sel_q = sel_cap_q;
  assign valid = valid_q;
  assign y_chg = chg_q;

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1 with a capture-history model checked every cycle.
module tb_mux_4to1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] s;
  logic [3:0] i;
  logic       y;
  logic [1:0] sel_q;
  logic       valid;
  logic       y_chg;

  int checks = 0;
  int errors = 0;

  mux_4to1 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .s     (s),
    .i     (i),
    .y     (y),
    .sel_q (sel_q),
    .valid (valid),
    .y_chg (y_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a history of captured samples since the last reset.
  int hist_y[$];
  int hist_s[$];
  bit last_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_y.delete();
      hist_s.delete();
      last_en = 1'b0;
    end else begin
      last_en = en;
      if (en) begin
        hist_y.push_back((int'(i) >> int'(s)) & 1);
        hist_s.push_back(int'(s));
      end
    end
  end

  function automatic int exp_y();
    return (hist_y.size() > 0) ? hist_y[hist_y.size()-1] : 0;
  endfunction

  function automatic int exp_sel();
    return (hist_s.size() > 0) ? hist_s[hist_s.size()-1] : 0;
  endfunction

  function automatic int exp_valid();
    return (hist_y.size() > 0) ? 1 : 0;
  endfunction

  function automatic int exp_chg();
    int n;
    n = hist_y.size();
    if (last_en && n >= 2 && hist_y[n-1] != hist_y[n-2]) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit done = 1'b0;

  always @(negedge clk) begin
    if (!done) begin
      chk("model_y",     int'(y),     exp_y());
      chk("model_sel",   int'(sel_q), exp_sel());
      chk("model_valid", int'(valid), exp_valid());
      chk("model_chg",   int'(y_chg), exp_chg());
    end
  end

  // Apply inputs just after an edge, then let the next edge capture them.
  task automatic drive(input logic e, input logic [1:0] sv, input logic [3:0] iv);
    en = e;
    s  = sv;
    i  = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    s   = 2'd0;
    i   = 4'd0;
    @(posedge clk);
    #1;
    chk("rst_y",     int'(y),     0);
    chk("rst_valid", int'(valid), 0);
    rst = 1'b0;

    // Async reset while y is 1.
    drive(1'b1, 2'd3, 4'b1000);
    chk("pre_rst_y", int'(y), 1);
    chk("pre_rst_sel", int'(sel_q), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y",     int'(y),     0);
    chk("async_rst_sel",   int'(sel_q), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_chg",   int'(y_chg), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First capture after reset: no change pulse.
    drive(1'b1, 2'd2, 4'b1111);
    chk("first_y",     int'(y),     1);
    chk("first_valid", int'(valid), 1);
    chk("first_chg",   int'(y_chg), 0);

    // Static select over 4'b0101.
    drive(1'b1, 2'd0, 4'b0101);
    chk("static0_y", int'(y), 1);
    drive(1'b1, 2'd1, 4'b0101);
    chk("static1_y", int'(y), 0);
    chk("static1_sel", int'(sel_q), 1);
    chk("static1_chg", int'(y_chg), 1);
    drive(1'b1, 2'd2, 4'b0101);
    chk("static2_y", int'(y), 1);
    drive(1'b1, 2'd3, 4'b0101);
    chk("static3_y", int'(y), 0);
    chk("static3_sel", int'(sel_q), 3);

    // Counter sweep with wrap of both s and i.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'(k % 4), 4'(k % 16));
      if (k == 15) chk("sweep_i15_s3_y", int'(y), 1);
      if (k == 16) chk("sweep_wrap_y", int'(y), 0);
    end

    // Enable hold.
    drive(1'b1, 2'd1, 4'b0010);
    chk("hold_cap_y", int'(y), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'd1, 4'b0000);
      chk("hold_y",   int'(y),     1);
      chk("hold_chg", int'(y_chg), 0);
    end
    drive(1'b1, 2'd1, 4'b0000);
    chk("reen_y",   int'(y),     0);
    chk("reen_chg", int'(y_chg), 1);
    drive(1'b1, 2'd1, 4'b0000);
    chk("reen_chg_end", int'(y_chg), 0);

    // Reset during a sweep.
    for (int k = 0; k < 6; k++) drive(1'b1, 2'(k % 4), 4'((k * 5) % 16));
    en = 1'b1;
    s  = 2'd1;
    i  = 4'b0010;
    pulse_reset();
    chk("sweep_rst_y",     int'(y),     0);
    chk("sweep_rst_valid", int'(valid), 0);
    drive(1'b1, 2'd3, 4'b1001);
    chk("post_rst_y",     int'(y),     1);
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_chg",   int'(y_chg), 0);
    drive(1'b1, 2'd2, 4'b1001);
    chk("post_rst_chg2", int'(y_chg), 1);

    @(negedge clk);
    done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4to1
